// File: rtl/bgpu_pkg.sv
// Shared types for the result collector: writeback entry layout and iid helpers.
// Widths here match the default build of result_collector.
package bgpu_pkg;

  localparam int unsigned RcNumTags     = 8;
  localparam int unsigned RcRegWidth    = 32;
  localparam int unsigned RcWarpWidth   = 4;
  localparam int unsigned RcNumWarps    = 8;
  localparam int unsigned RcRegIdxWidth = 8;

  localparam int unsigned RcTagWidth  = $clog2(RcNumTags);
  localparam int unsigned RcWidWidth  = RcNumWarps > 1 ? $clog2(RcNumWarps) : 1;
  localparam int unsigned RcIidWidth  = RcTagWidth + RcWidWidth;
  localparam int unsigned RcDataWidth = RcRegWidth * RcWarpWidth;

  typedef logic [RcIidWidth-1:0]    iid_t;
  typedef logic [RcWidWidth-1:0]    wid_t;
  typedef logic [RcRegIdxWidth-1:0] reg_idx_t;
  typedef logic [RcWarpWidth-1:0]   act_mask_t;
  typedef logic [RcDataWidth-1:0]   warp_data_t;

  typedef struct packed {
    iid_t       iid;
    reg_idx_t   dst;
    act_mask_t  act_mask;
    warp_data_t data;
  } rc_entry_t;

  // The warp ID lives in the low bits of the instruction ID.
  function automatic wid_t get_wid(iid_t iid);
    return iid[RcWidWidth-1:0];
  endfunction

endpackage

// File: rtl/rc_rr_arbiter.sv
// Round-robin arbiter with grant lock: a grant that is not acknowledged is held
// until it is, and the priority pointer advances past the winner on acknowledge.
module rc_rr_arbiter #(
  parameter  int unsigned NumReq   = 2,
  localparam int unsigned IdxWidth = NumReq > 1 ? $clog2(NumReq) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumReq-1:0]   req_i,
  input  logic                ack_i,
  output logic [NumReq-1:0]   gnt_o,
  output logic [IdxWidth-1:0] idx_o,
  output logic                valid_o
);

  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
  logic                lock_q, lock_d;
  logic [IdxWidth-1:0] rr_idx, cand;
  logic                rr_valid;

  // First requester at or after the pointer, with wrap.
  always_comb begin
    rr_idx   = '0;
    rr_valid = 1'b0;
    cand     = '0;
    for (int k = 0; k < int'(NumReq); k++) begin
      cand = IdxWidth'((int'(ptr_q) + k) % int'(NumReq));
      if (!rr_valid && req_i[cand]) begin
        rr_idx   = cand;
        rr_valid = 1'b1;
      end
    end
  end

  always_comb begin
    if (lock_q) begin
      idx_o   = lock_idx_q;
      valid_o = req_i[lock_idx_q];
    end else begin
      idx_o   = rr_idx;
      valid_o = rr_valid;
    end
    gnt_o = valid_o ? (NumReq'(1) << idx_o) : '0;
  end

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = 1'b0;
    lock_idx_d = lock_idx_q;
    if (valid_o && ack_i) begin
      ptr_d = (idx_o == IdxWidth'(NumReq - 1)) ? '0 : idx_o + 1'b1;
    end else if (valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = idx_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/result_collector.sv
// Arbitrates execution-unit results onto the register-file write port and pulses
// completion per retired entry. BGPU_RC_OUTPUT_REG_EN adds a one-entry output register.
module result_collector
  import bgpu_pkg::*;
#(
  parameter  int unsigned NumEus      = 2,
  parameter  int unsigned NumTags     = RcNumTags,
  parameter  int unsigned RegWidth    = RcRegWidth,
  parameter  int unsigned WarpWidth   = RcWarpWidth,
  parameter  int unsigned NumWarps    = RcNumWarps,
  parameter  int unsigned RegIdxWidth = RcRegIdxWidth,
  localparam int unsigned TagWidth    = $clog2(NumTags),
  localparam int unsigned WidWidth    = NumWarps > 1 ? $clog2(NumWarps) : 1,
  localparam int unsigned IidWidth    = TagWidth + WidWidth,
  localparam int unsigned DataWidth   = RegWidth * WarpWidth,
  localparam int unsigned IdxWidth    = NumEus > 1 ? $clog2(NumEus) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumEus-1:0]                   eu_to_rc_valid_i,
  output logic [NumEus-1:0]                   rc_to_eu_ready_o,
  input  logic [NumEus-1:0][IidWidth-1:0]     eu_to_rc_tag_i,
  input  logic [NumEus-1:0][RegIdxWidth-1:0]  eu_to_rc_dst_i,
  input  logic [NumEus-1:0][WarpWidth-1:0]    eu_to_rc_act_mask_i,
  input  logic [NumEus-1:0][DataWidth-1:0]    eu_to_rc_data_i,
  output logic                                rc_to_rf_valid_o,
  input  logic                                rf_to_rc_ready_i,
  output logic [WidWidth-1:0]                 rc_to_rf_wid_o,
  output logic [RegIdxWidth-1:0]              rc_to_rf_dst_o,
  output logic [WarpWidth-1:0]                rc_to_rf_act_mask_o,
  output logic [DataWidth-1:0]                rc_to_rf_data_o,
  output logic                                rc_to_wb_valid_o,
  output logic [IidWidth-1:0]                 rc_to_wb_iid_o
);

  logic [NumEus-1:0]   arb_gnt;
  logic [IdxWidth-1:0] arb_idx;
  logic                arb_valid;
  logic                accept, present, retire;
  rc_entry_t           in_entry, out_entry;

  rc_rr_arbiter #(
    .NumReq (NumEus)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (eu_to_rc_valid_i),
    .ack_i   (accept),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    in_entry          = '0;
    in_entry.iid      = eu_to_rc_tag_i[arb_idx];
    in_entry.dst      = eu_to_rc_dst_i[arb_idx];
    in_entry.act_mask = eu_to_rc_act_mask_i[arb_idx];
    in_entry.data     = eu_to_rc_data_i[arb_idx];
  end

`ifdef BGPU_RC_OUTPUT_REG_EN
  rc_entry_t entry_q, entry_d;
  logic      full_q, full_d;

  assign present   = full_q && !rst_i;
  assign out_entry = entry_q;
  // Zero-mask entries retire without waiting for the register file.
  assign retire    = present && ((out_entry.act_mask == '0) || rf_to_rc_ready_i);
  assign accept    = arb_valid && !rst_i && (!full_q || retire);

  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (accept) begin
      full_d  = 1'b1;
      entry_d = in_entry;
    end else if (retire) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end
`else
  assign present   = arb_valid && !rst_i;
  assign out_entry = present ? in_entry : '0;
  assign retire    = present && ((out_entry.act_mask == '0) || rf_to_rc_ready_i);
  assign accept    = retire;
`endif

  assign rc_to_eu_ready_o    = accept ? arb_gnt : '0;
  assign rc_to_rf_valid_o    = present && (out_entry.act_mask != '0);
  assign rc_to_rf_wid_o      = get_wid(out_entry.iid);
  assign rc_to_rf_dst_o      = out_entry.dst;
  assign rc_to_rf_act_mask_o = out_entry.act_mask;
  assign rc_to_rf_data_o     = out_entry.data;
  assign rc_to_wb_valid_o    = retire;
  assign rc_to_wb_iid_o      = out_entry.iid;

endmodule
